wallace_mult_pipe: RTL
======================

Name: wallace_mult_pipe

Overview:
- Parametrised, pipelined unsigned multiplier. Built from a carry-save-adder Wallace reduction tree with a final carry-propagate adder.
- Generalises the fixed 24x24 combinational multiplier in two ways: operand width is configurable, and the CSA tree is cut into registered stages.
- Uses valid/ready handshakes on both ports, so the SPFP datapath can issue one multiply per cycle under backpressure.
- Sits between SPFP operand unpack (mantissa with hidden bit) and normalise/round.

Parameters:
- WIDTH, 24, operand width in bits; legal range 4..32.
- STAGES, 3, pipeline register stages from accept to output; legal range 1..4. Latency equals STAGES cycles.
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  op1/op2/in_tag are valid.
- in_ready  out  1  block accepts an operation this cycle.
- op1  in  WIDTH  multiplicand.
- op2  in  WIDTH  multiplier.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  product/out_tag are valid.
- out_ready  in  1  downstream accepts the result.
- product  out  2*WIDTH  full-width product op1*op2; no truncation and no carry-out.
- out_tag  out  TAG_W  tag of the operation whose product is presented.
- busy  out  1  high when any pipeline stage holds a valid operation.

Behaviour:
- Reset (rst_n low, asynchronous): clear all stage valid bits. Outputs take these values:
  - out_valid = 0
  - busy = 0
  - product = 0
  - out_tag = 0
  - in_ready = 1 once rst_n is high
- Pipeline data registers need not be cleared, but product and out_tag must read 0 until the first out_valid.
- Partial products: pp[i] = op2[i] ? (op1 << i) : 0, for i = 0..WIDTH-1, each 2*WIDTH bits wide.
- Reduction: 3:2 CSA levels until two rows remain, then one 2*WIDTH-bit carry-propagate add. Arithmetic is modulo 2^(2*WIDTH), which is exact for unsigned operands.
- Stage split:
  - Stage 1 registers the partial-product rows, or the first CSA level's outputs.
  - Stages 2..STAGES-1 each absorb a roughly equal number of CSA levels.
  - The final stage registers the CPA result.
  - STAGES=1 means the whole tree plus CPA sits in one register stage.
  - The stage split is an implementation choice; latency is not.
- Transfer rule: an operation is accepted when in_valid && in_ready, and delivered when out_valid && out_ready.
- Latency: an operation accepted at edge N presents out_valid=1 after edge N+STAGES, provided no stall occurred.
- Stall: stall = out_valid && !out_ready.
  - On stall, every stage holds its contents and in_ready = 0.
  - Otherwise all stages advance and in_ready = 1.
  - Bubbles are not compressed; the pipeline is a simple enable-gated shift.
- No combinational path from in_valid to out_valid.
- in_ready depends only on out_valid and out_ready.
- Throughput: one operation per cycle while out_ready is held high.
- Ordering: results emerge strictly in acceptance order; each tag stays paired with its own operands.
- Stall hold rule: product and out_tag must not change while out_valid=1 and out_ready=0.
- busy = OR of all stage valid bits.
- Edge cases:
  - Zero operand gives product 0.
  - op1 = op2 = 2^WIDTH-1 gives 2^(2*WIDTH) - 2^(WIDTH+1) + 1.
  - Simultaneous in_valid and out_ready while full: the delivered result leaves and the new operation enters in the same cycle.
  - rst_n asserted mid-operation: all in-flight operations are discarded; no out_valid pulse follows reset release until a new acceptance.

Optional Feature:
- Macro: WALLACE_MULT_SIGNED_EN.
- When defined:
  - Adds input port op_signed (1 bit), sampled with op1/op2 at acceptance and pipelined with the operation.
  - op_signed=1 treats op1/op2 as two's complement and produces a 2*WIDTH-bit two's-complement product. Use Baugh-Wooley or sign-extended partial products.
  - op_signed=0 gives the unsigned behaviour above.
- When undefined: the op_signed port does not exist and the block is unsigned only, with identical latency and handshake.

Test Plan:
- WIDTH=24, STAGES=3, out_ready=1: op1=0xFFFFFF, op2=0xFFFFFF, tag=0x5, accepted at edge 0 -> out_valid at edge 3, product=0xFFFFFE000001, out_tag=0x5; op1=0x800000, op2=0x000002 -> product=0x000001000000.
- Back-to-back: 8 operations on consecutive cycles with op1=i+1, op2=0x000100 and tags 0..7 -> 8 consecutive out_valid cycles starting at edge 3, product=(i+1)<<8, tags in order 0..7.
- Backpressure: fill the pipe, hold out_ready=0 for 5 cycles -> in_ready=0, product/out_tag stable. Release -> all results delivered in order, none lost or duplicated.
- Reset mid-flight: accept 2 operations, pull rst_n low asynchronously between edges -> out_valid=0, busy=0, product=0 immediately. After release, no stale results are delivered.
- Parameter sweep WIDTH=8 with STAGES=1, 2 and 4: 0xFF*0xFF -> 0xFE01 at latency 1/2/4. Also run 1000 random unsigned vectors against a reference model.
- With WALLACE_MULT_SIGNED_EN, WIDTH=24:
  - op_signed=1, 0xFFFFFF*0xFFFFFF -> 0x000000000001.
  - 0x800000*0x800000 -> 0x400000000000.
  - 0x800000*0x000001 -> 0xFFFFFF800000.
  - op_signed=0, same operands -> the unsigned results.

Source files
------------

// File: rtl/wallace_mult_pipe_if.sv
// Handshake bundle for wallace_mult_pipe: operand/tag request side and
// product/tag response side, each with its own valid/ready pair.
// Optional macro WALLACE_MULT_SIGNED_EN adds the op_signed request bit.
interface wallace_mult_pipe_if #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op2;
  logic [TAG_W-1:0]   in_tag;
`ifdef WALLACE_MULT_SIGNED_EN
  logic               op_signed;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, op1, op2, in_tag, out_ready,
`ifdef WALLACE_MULT_SIGNED_EN
    output op_signed,
`endif
    input  in_ready, out_valid, product, out_tag, busy
  );

  // Multiplier side
  modport slave (
    input  in_valid, op1, op2, in_tag, out_ready,
`ifdef WALLACE_MULT_SIGNED_EN
    input  op_signed,
`endif
    output in_ready, out_valid, product, out_tag, busy
  );
endinterface

// File: rtl/wallace_mult_pipe.sv
// Pipelined WIDTH x WIDTH multiplier: partial products, 3:2 CSA (Wallace)
// reduction, final carry-propagate add, cut into STAGES registered stages.
// Stage 1 holds the partial-product rows, the middle stages share the CSA
// levels, and the last stage holds the CPA result (STAGES=1 puts all of it
// in one stage). Enable-gated shift pipeline: a stalled output freezes
// every stage. Define WALLACE_MULT_SIGNED_EN to add two's-complement
// operation selected per operation by op_signed.
module wallace_mult_pipe #(
  parameter int WIDTH  = 24,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  wallace_mult_pipe_if.slave bus
);

  localparam int PW = 2 * WIDTH;

  typedef logic [WIDTH-1:0][PW-1:0] rows_t;

  // Row count left after 'lvl' CSA levels (each group of 3 rows becomes 2).
  function automatic int rows_at(int lvl);
    int n;
    n = WIDTH;
    for (int l = 0; l < lvl; l++) n = n - n / 3;
    return n;
  endfunction

  function automatic int count_levels();
    int n;
    int l;
    n = WIDTH;
    l = 0;
    while (n > 2) begin
      n = n - n / 3;
      l++;
    end
    return l;
  endfunction

  localparam int NLVL = count_levels();

  // One 3:2 compression level over the first n rows; results are packed
  // from row 0 upward, leftover rows pass straight through.
  function automatic rows_t csa_level(rows_t r, int n);
    rows_t         o;
    logic [PW-1:0] a, b, c, maj;
    o = '0;
    for (int i = 0; i < WIDTH / 3; i++) begin
      if (i < n / 3) begin
        a   = r[3*i];
        b   = r[3*i+1];
        c   = r[3*i+2];
        maj = (a & b) | (a & c) | (b & c);
        o[2*i]   = a ^ b ^ c;
        o[2*i+1] = {maj[PW-2:0], 1'b0};
      end
    end
    for (int j = 0; j < 2; j++) begin
      if (j < n % 3) o[2*(n/3)+j] = r[3*(n/3)+j];
    end
    return o;
  endfunction

  function automatic rows_t reduce(rows_t r, int lo, int hi);
    rows_t t;
    t = r;
    for (int l = 0; l < NLVL; l++) begin
      if (l >= lo && l < hi) t = csa_level(t, rows_at(l));
    end
    return t;
  endfunction

  // Number of CSA levels completed at the output of stage s.
  function automatic int lvl_end(int s);
    if (s == STAGES) return NLVL;
    if (s == 1) return 0;
    return ((s - 1) * NLVL) / (STAGES > 2 ? STAGES - 2 : 1);
  endfunction

  function automatic int lvl_start(int s);
    return (s == 1) ? 0 : lvl_end(s - 1);
  endfunction

  // Combinational work of stage s; the last stage adds the two final rows.
  function automatic rows_t stage_fn(int s, rows_t r);
    rows_t t, o;
    t = reduce(r, lvl_start(s), lvl_end(s));
    o = t;
    if (s == STAGES) begin
      o    = '0;
      o[0] = t[0] + t[1];
    end
    return o;
  endfunction

  logic [PW-1:0]    a_ext;
  rows_t            pp_rows;
  rows_t            stg_in;
  rows_t            stg_nxt [1:STAGES];
  rows_t            rows_p  [1:STAGES];
  logic [TAG_W-1:0] tag_p   [1:STAGES];
  logic [STAGES:1]  vld_p;
  logic             stall;
  logic             adv;

`ifdef WALLACE_MULT_SIGNED_EN
  logic signed [PW-1:0] a_sx;
  assign a_sx  = PW'($signed(bus.op1));
  assign a_ext = bus.op_signed ? a_sx : PW'(bus.op1);
`else
  assign a_ext = PW'(bus.op1);
`endif

  // Partial-product rows; in signed mode the MSB row carries weight -2^(W-1)
  always_comb begin
    pp_rows = '0;
    for (int i = 0; i < WIDTH; i++) pp_rows[i] = bus.op2[i] ? (a_ext << i) : '0;
`ifdef WALLACE_MULT_SIGNED_EN
    if (bus.op_signed) pp_rows[WIDTH-1] = -pp_rows[WIDTH-1];
`endif
  end

  // Next-state of each stage from the previous stage's registers
  always_comb begin
    stg_in = pp_rows;
    for (int s = 1; s <= STAGES; s++) begin
      stg_nxt[s] = stage_fn(s, stg_in);
      stg_in     = rows_p[s];
    end
  end

  assign stall = vld_p[STAGES] & ~bus.out_ready;
  assign adv   = ~stall;

  // Stage valid bits: the only reset state; shift when not stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p[1] <= bus.in_valid;
      for (int s = 2; s <= STAGES; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  // Stage data and tags advance with the valid bits; no reset needed
  always_ff @(posedge clk) begin
    if (adv) begin
      tag_p[1] <= bus.in_tag;
      for (int s = 2; s <= STAGES; s++) tag_p[s] <= tag_p[s-1];
      for (int s = 1; s <= STAGES; s++) rows_p[s] <= stg_nxt[s];
    end
  end

  // ---- output stage: data gated so it reads 0 whenever nothing is valid
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_p[STAGES];
  assign bus.product   = vld_p[STAGES] ? rows_p[STAGES][0] : '0;
  assign bus.out_tag   = vld_p[STAGES] ? tag_p[STAGES] : '0;
  assign bus.busy      = |vld_p;

endmodule
